// File: rtl/mux32_rr_arbiter_if.sv
// Handshake bundle between the round-robin arbiter, its requesters and the downstream consumer.
// master: arbiter side; slave: requester/consumer side.
interface mux32_rr_arbiter_if;
    logic [31:0] REQ;
    logic        READY;
    logic [31:0] GNT;
    logic [4:0]  SEL;
    logic        VALID;
    logic        TIMEOUT;

    modport master (
        input  REQ,
        input  READY,
        output GNT,
        output SEL,
        output VALID,
        output TIMEOUT
    );

    modport slave (
        output REQ,
        output READY,
        input  GNT,
        input  SEL,
        input  VALID,
        input  TIMEOUT
    );
endinterface

// File: rtl/mux32_rr_arbiter.sv
// Round-robin arbiter driving the MUX32_32x1 select, bursts bounded by MAX_BURST.
// Optional stall-timeout forced release when ARB_STALL_TIMEOUT_EN is defined.
module mux32_rr_arbiter #(
    parameter int unsigned MAX_BURST   = 4,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    mux32_rr_arbiter_if.master     bus
);

    if (MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_burst
        $error("MAX_BURST must be in 1..16");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 32) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be in 1..32");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t      st_q, st_d;
    logic [4:0]  ptr_q, ptr_d;
    logic [4:0]  sel_q, sel_d;
    logic [31:0] gnt_q, gnt_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        timeout_q, timeout_d;

    logic        valid, xfer;
    logic        rel_burst, rel_timeout, release_now;
    logic [4:0]  next_ptr;

    // Rotate so bit 0 is the pointer position, then take the lowest set bit.
    function automatic logic [4:0] pick(input logic [31:0] req, input logic [4:0] ptr);
        logic [63:0] dbl;
        logic [31:0] rot;
        logic [4:0]  off;
        dbl = {req, req} >> ptr;
        rot = dbl[31:0];
        off = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (rot[31 - i]) off = 5'(31 - i);
        end
        return ptr + off;
    endfunction

    always_comb begin : out_comb
        valid = (st_q == GRANT) && bus.REQ[sel_q];
        xfer  = valid && bus.READY;
    end

    assign bus.VALID   = valid;
    assign bus.GNT     = gnt_q;
    assign bus.SEL     = sel_q;
    assign bus.TIMEOUT = timeout_q;

`ifdef ARB_STALL_TIMEOUT_EN
    logic [4:0] stall_q, stall_d;

    assign rel_timeout = valid && !bus.READY && (stall_q == 5'(TIMEOUT_CYC - 1));

    always_comb begin : stall_comb
        stall_d   = stall_q;
        timeout_d = rel_timeout;
        if (xfer || release_now) stall_d = '0;
        else if (valid && !bus.READY) stall_d = stall_q + 5'd1;
    end

    always_ff @(posedge CLK) begin : stall_reg
        if (RST) stall_q <= '0;
        else     stall_q <= stall_d;
    end
`else
    assign rel_timeout = 1'b0;
    assign timeout_d   = 1'b0;
`endif

    assign rel_burst   = xfer && (cnt_q == 4'(MAX_BURST - 1));
    assign release_now = (st_q == GRANT) && (!bus.REQ[sel_q] || rel_burst || rel_timeout);
    assign next_ptr    = sel_q + 5'd1;

    always_comb begin : next_comb
        st_d  = st_q;
        ptr_d = ptr_q;
        sel_d = sel_q;
        gnt_d = gnt_q;
        cnt_d = cnt_q;
        case (st_q)
            IDLE: begin
                if (|bus.REQ) begin
                    sel_d = pick(bus.REQ, ptr_q);
                    gnt_d = 32'h1 << sel_d;
                    cnt_d = '0;
                    st_d  = GRANT;
                end
            end
            GRANT: begin
                if (xfer) cnt_d = cnt_q + 4'd1;
                // Release re-arbitrates from the advanced pointer in the same edge.
                if (release_now) begin
                    ptr_d = next_ptr;
                    cnt_d = '0;
                    if (|bus.REQ) begin
                        sel_d = pick(bus.REQ, next_ptr);
                        gnt_d = 32'h1 << sel_d;
                    end else begin
                        gnt_d = '0;
                        st_d  = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin : state_reg
        if (RST) begin
            st_q      <= IDLE;
            ptr_q     <= '0;
            sel_q     <= '0;
            gnt_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            st_q      <= st_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: doc/mux32_rr_arbiter.md
# mux32_rr_arbiter

Round-robin arbiter sharing the 32-bit 32x1 mux datapath (MUX32_32x1) among 32 requesters. Grants one requester at a time, drives the mux select `SEL` directly, and transfers data to a single downstream consumer with a valid/ready handshake. Grants are bursts bounded by `MAX_BURST` for fairness.

## Interface
- `MAX_BURST`, 4: maximum accepted transfers per grant; legal range 1..16.
- `TIMEOUT_CYC`, 16: stall cycles before forced release; only used with `ARB_STALL_TIMEOUT_EN`.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `REQ`  in  32  per-requester request; bit i = mux input Ii.
- `READY`  in  1  downstream accepts the current mux output.
- `GNT`  out  32  registered one-hot grant; all zero when idle.
- `SEL`  out  5  registered mux select; drives MUX32_32x1 `S`.
- `VALID`  out  1  mux output `Y` is a valid transfer this cycle.
- `TIMEOUT`  out  1  one-cycle pulse on forced release; constant 0 without the macro.

## Operation
- State: `st` in {IDLE, GRANT}, round-robin pointer `ptr[4:0]`, burst counter `cnt[3:0]`, stall counter `stall[4:0]` (macro only).
- Reset values: st=IDLE, GNT=0, SEL=0, ptr=0, cnt=0, stall=0, VALID=0, TIMEOUT=0.
- Pick function: first set bit of `REQ` searching upward from `ptr`, wrapping 31->0.
- IDLE: if REQ!=0, load SEL=pick, GNT=1<<pick, cnt=0, go GRANT. Otherwise stay.
- GRANT: VALID = REQ[SEL] (combinational from REQ, gated by st==GRANT). Transfer = VALID && READY at the edge.
- On a transfer, cnt increments.
- Release occurs at an edge when either:
  - REQ[SEL]==0 is sampled, or
  - a transfer occurs with cnt==MAX_BURST-1.
- On release: ptr = SEL+1 (mod 32). Re-arbitrate in the same edge using the new ptr.
  - If a requester is found, stay in GRANT with new SEL/GNT and cnt=0, with no bubble.
  - Otherwise GNT=0 and go IDLE.
- A lone requester that still holds REQ is re-granted immediately after its burst ends.
- REQ changes on non-granted bits have no effect until the next arbitration.
- RST asserted mid-burst: all state returns to reset values at that edge. Any in-flight transfer is dropped.

## Timing
- Grant latency: REQ sampled high at edge N in IDLE gives GNT/SEL valid after edge N. The first transfer is possible at edge N+1.
- Back-to-back: a burst of MAX_BURST transfers with READY=1 occupies exactly MAX_BURST cycles. The next grant is visible in the cycle immediately after the last transfer.
- READY low: GNT, SEL and cnt hold. VALID follows REQ[SEL].
- SEL never changes in a cycle where VALID && READY is not yet consumed. It changes only at release edges.

## Configuration
- `ARB_STALL_TIMEOUT_EN` defined:
  - `stall` increments each cycle with VALID && !READY, and clears on a transfer or on release.
  - When `stall` reaches TIMEOUT_CYC-1 with another stall cycle, that edge forces a release with normal pointer advance and re-arbitration.
  - TIMEOUT is high for the following cycle only.
- Not defined: no stall counter; a grant is held indefinitely under backpressure; TIMEOUT tied 0.

## Test plan
- Reset: RST=1 for 2 cycles with REQ=32'hFFFFFFFF → GNT=0, SEL=0, VALID=0. After RST falls: GNT=32'h1 one edge later, then a transfer from I0.
- Rotation: MAX_BURST=4, READY=1, REQ=32'h00000105 held → SEL sequence 0,2,8,0, each held 4 cycles, no idle cycle between bursts.
- Wrap-around: drive ptr to 31 by granting requester 30, then REQ=32'h80000002 → grant 31 first, then 1.
- Backpressure: READY=0 for 3 cycles mid-burst → GNT/SEL/cnt unchanged and VALID=1 throughout. The burst completes after READY returns, with the full 4 transfers.
- Early drop: requester 5 drops REQ after 2 of 4 transfers with REQ[9] pending → release at the next edge and grant 9. No transfer is counted from 5 after the drop.
- Timeout (macro defined, TIMEOUT_CYC=16): READY=0 for 16 cycles with REQ=32'h00000011 and grant on 0 → TIMEOUT pulses one cycle and grant moves to 4. Without the macro: grant stays on 0 and TIMEOUT=0.
